data_mem_responder: RTL and testbench

Data-memory responder for the pipelined RSA CPU. It serves the core's memory-stage interface: MemWrite, ALUResult as the byte address, WriteData in, and ReadData out.
- Contains a word-organised RAM plus a small memory-mapped I/O window: DONE register, cycle counter, status.
- A host-side load port fills RAM (keys, message) before releasing the core via start.
- A 3-state sequencer controls the flow LOAD -> RUN -> DONE.

---
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipelined RSA CPU: word RAM, host load port and a small I/O window.
// A LOAD -> RUN -> DONE sequencer gates the core and measures its run time.
//
// state  | meaning
// S_LOAD | host fills RAM, core held off (start=0, host_ready=1)
// S_RUN  | core runs, cycle counter advances (start=1)
// S_DONE | core has signalled completion, counter frozen (done=1)
module data_mem_responder #(
  parameter int          DEPTH   = 256,
  parameter logic [31:0] IO_BASE = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        FlagZero,
  output logic [31:0] ReadData,
  output logic        start,
  output logic        done,
  output logic [31:0] cycle_count,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [7:0]  host_addr,
  input  logic [31:0] host_wdata,
  input  logic        host_last,
  input  logic        host_restart,
  output logic [31:0] host_rdata
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic        r_start;
  logic        r_done;
  logic        r_host_ready;
  logic [31:0] r_cycle;
  logic [31:0] r_mem [DEPTH];

  logic [31:0]   w_word;
  logic          w_in_ram;
  logic [AW-1:0] w_core_idx;
  logic [AW-1:0] w_host_idx;
  logic          w_host_xfer;
  logic          w_core_ram_wr;
  logic          w_done_wr;
  logic [31:0]   w_rdata;
  logic [1:0]    w_unused;

  assign w_word        = {ALUResult[31:2], 2'b00};
  assign w_unused      = ALUResult[1:0];
  assign w_in_ram      = (w_word < RAM_BYTES);
  assign w_core_idx    = ALUResult[AW+1:2];
  assign w_host_idx    = AW'(host_addr);
  assign w_host_xfer   = host_valid & r_host_ready;
  assign w_core_ram_wr = MemWrite & (r_state == S_RUN) & w_in_ram;
  assign w_done_wr     = MemWrite & (r_state == S_RUN) & (w_word == IO_BASE) & WriteData[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_start      <= 1'b0;
      r_done       <= 1'b0;
      r_host_ready <= 1'b1;
      r_cycle      <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_host_xfer && host_last) begin
            r_state      <= S_RUN;
            r_start      <= 1'b1;
            r_host_ready <= 1'b0;
            r_cycle      <= '0;
          end
        end
        S_RUN: begin
          // Counter still advances on the cycle the core signals completion.
          r_cycle <= r_cycle + 32'd1;
          if (w_done_wr) begin
            r_state <= S_DONE;
            r_start <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (host_restart) begin
            r_state      <= S_LOAD;
            r_done       <= 1'b0;
            r_host_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_LOAD;
          r_start      <= 1'b0;
          r_done       <= 1'b0;
          r_host_ready <= 1'b1;
        end
      endcase
    end
  end

  // RAM has no reset so its contents survive a mid-run reset; host and core ports are state-exclusive.
  always_ff @(posedge clk) begin
    if (w_host_xfer)
      r_mem[w_host_idx] <= host_wdata;
    else if (w_core_ram_wr)
      r_mem[w_core_idx] <= WriteData;
  end

  always_comb begin
    w_rdata = '0;
    if (w_in_ram)
      w_rdata = r_mem[w_core_idx];
    else if (w_word == IO_BASE + 32'd4)
      w_rdata = r_cycle;
    else if (w_word == IO_BASE + 32'd8)
      w_rdata = {29'b0, r_done, FlagZero, r_start};
  end

  assign ReadData    = w_rdata;
  assign host_rdata  = r_mem[w_host_idx];
  assign start       = r_start;
  assign done        = r_done;
  assign host_ready  = r_host_ready;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: host load, core RAM/I/O access,
// completion, restart and mid-run reset.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        FlagZero;
  logic [31:0] ReadData;
  logic        start;
  logic        done;
  logic [31:0] cycle_count;
  logic        host_valid;
  logic        host_ready;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_last;
  logic        host_restart;
  logic [31:0] host_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .FlagZero     (FlagZero),
    .ReadData     (ReadData),
    .start        (start),
    .done         (done),
    .cycle_count  (cycle_count),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_last    (host_last),
    .host_restart (host_restart),
    .host_rdata   (host_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; ALUResult = '0; WriteData = '0; FlagZero = 1'b0;
    host_valid = 1'b0; host_addr = '0; host_wdata = '0; host_last = 1'b0; host_restart = 1'b0;
    #3;
    chk("rst_start", {31'b0, start}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_host_ready", {31'b0, host_ready}, 32'd1);
    @(negedge clk); reset = 1'b0;
    tick(1);

    // host_last without host_valid must not start the core
    host_last = 1'b1;
    tick(1);
    host_last = 1'b0;
    chk("last_no_valid", {31'b0, start}, 32'd0);

    host_valid = 1'b1; host_addr = 8'd0; host_wdata = 32'h1111_1111;
    tick(1);
    host_addr = 8'd3; host_wdata = 32'hDEAD_BEEF; #1;
    chk("t1_ready_a", {31'b0, host_ready}, 32'd1);
    tick(1);
    host_addr = 8'd4; host_wdata = 32'h1234_5678; host_last = 1'b1; #1;
    chk("t1_ready_b", {31'b0, host_ready}, 32'd1);
    chk("t1_start_pre", {31'b0, start}, 32'd0);
    tick(1);
    host_valid = 1'b0; host_last = 1'b0; host_addr = 8'd3; #1;
    chk("t1_start", {31'b0, start}, 32'd1);
    chk("t1_cycle_entry", cycle_count, 32'd0);
    chk("t1_ready_run", {31'b0, host_ready}, 32'd0);
    chk("t1_hrdata3", host_rdata, 32'hDEAD_BEEF);

    // RUN cycle 0: store, same-cycle read returns old contents
    MemWrite = 1'b1; ALUResult = 32'h10; WriteData = 32'hA5A5_A5A5; #1;
    chk("t2_old_data", ReadData, 32'h1234_5678);
    tick(1);
    MemWrite = 1'b0; #1;
    chk("t2_load10", ReadData, 32'hA5A5_A5A5);
    ALUResult = 32'h13; host_addr = 8'd4; #1;
    chk("t2_load13", ReadData, 32'hA5A5_A5A5);
    chk("t2_hrdata4", host_rdata, 32'hA5A5_A5A5);

    FlagZero = 1'b1; ALUResult = 32'h408; #1;
    chk("t3_status_z1", ReadData, 32'h3);
    FlagZero = 1'b0; #1;
    chk("t3_status_z0", ReadData, 32'h1);
    ALUResult = 32'h400; #1;
    chk("t3_done_reg_rd", ReadData, 32'h0);
    tick(9);
    ALUResult = 32'h404; #1;
    chk("t3_cycle10", ReadData, 32'd10);

    // out-of-range store must not alias onto RAM word 0
    MemWrite = 1'b1; ALUResult = 32'h800; WriteData = 32'hFFFF_FFFF;
    tick(1);
    MemWrite = 1'b0; host_addr = 8'd0; #1;
    chk("t5_oor_read", ReadData, 32'h0);
    chk("t5_ram0", host_rdata, 32'h1111_1111);
    host_valid = 1'b1; host_addr = 8'd3; host_wdata = 32'h0; host_last = 1'b1; #1;
    chk("t5_ready_run", {31'b0, host_ready}, 32'd0);
    tick(1);
    host_valid = 1'b0; host_last = 1'b0; #1;
    chk("t5_ram3", host_rdata, 32'hDEAD_BEEF);
    // DONE write with bit0 clear keeps running
    MemWrite = 1'b1; ALUResult = 32'h400; WriteData = 32'h2;
    tick(1);
    MemWrite = 1'b0; #1;
    chk("t5_done_bit0_clr", {31'b0, start}, 32'd1);
    tick(7);
    chk("t4_cycle20", cycle_count, 32'd20);
    MemWrite = 1'b1; ALUResult = 32'h400; WriteData = 32'h1;
    tick(1);
    chk("t4_start", {31'b0, start}, 32'd0);
    chk("t4_done", {31'b0, done}, 32'd1);
    chk("t4_cycle21", cycle_count, 32'd21);
    ALUResult = 32'h10; WriteData = 32'h0;
    tick(3);
    MemWrite = 1'b0; #1;
    chk("t4_ram_locked", ReadData, 32'hA5A5_A5A5);
    chk("t4_cycle_frozen", cycle_count, 32'd21);
    host_addr = 8'd4; #1;
    chk("t4_hrdata4", host_rdata, 32'hA5A5_A5A5);
    ALUResult = 32'h408; #1;
    chk("t4_status_done", ReadData, 32'h4);

    host_restart = 1'b1;
    tick(1);
    host_restart = 1'b0;
    chk("t6_restart_ready", {31'b0, host_ready}, 32'd1);
    chk("t6_restart_done", {31'b0, done}, 32'd0);
    chk("t6_restart_cycle", cycle_count, 32'd21);

    host_valid = 1'b1; host_addr = 8'd5; host_wdata = 32'h55; host_last = 1'b1;
    tick(1);
    host_valid = 1'b0; host_last = 1'b0;
    chk("t6_rerun_cycle", cycle_count, 32'd0);
    tick(2);
    chk("t6_rerun_cycle2", cycle_count, 32'd2);
    reset = 1'b1; host_addr = 8'd3; #1;
    chk("t6_rst_start", {31'b0, start}, 32'd0);
    chk("t6_rst_ready", {31'b0, host_ready}, 32'd1);
    chk("t6_rst_cycle", cycle_count, 32'd0);
    chk("t6_rst_ram3", host_rdata, 32'hDEAD_BEEF);
    @(negedge clk); reset = 1'b0;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
